prog_loader: RTL
================

# prog_loader

Hardware program loader and run controller for `Simple_Single_CPU`. It receives a byte stream, packs it big-endian into 32-bit instruction words, and writes them into the instruction memory while holding the CPU in reset. It then releases the CPU for a fixed number of cycles and flags when the run budget has expired, so the register file and data memory can be sampled at a deterministic point. It is the in-system writer of instruction memory, sitting between a host byte link and the CPU's IM write port and reset input.

## Interface
- `WORDS`, 128: instruction memory depth in 32-bit words; `AW = $clog2(WORDS)`.
- `RUN_CYCLES`, 600: number of clock edges the CPU runs after release before `halt_o` asserts.
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  one-cycle request to begin a load; sampled only in IDLE, RUN and HALT.
- `len_i`  in  AW+1  number of words to load, valid with `start_i`; legal range 1..WORDS.
- `byte_valid_i`  in  1  stream byte available.
- `byte_data_i`  in  8  stream byte; the first byte of each word is bits [31:24].
- `byte_ready_o`  out  1  loader accepts a byte this cycle.
- `im_we_o`  out  1  instruction memory write strobe.
- `im_addr_o`  out  AW  word address of the write.
- `im_wdata_o`  out  32  instruction word.
- `cpu_rst_n_o`  out  1  drives the CPU's active-low `rst_i`; 0 holds the CPU in reset.
- `busy_o`  out  1  high in LOAD and WRITE.
- `halt_o`  out  1  high in HALT.
- `err_o`  out  1  sticky; set by an illegal `len_i` and cleared by the next `start_i`.

## Operation
- States: IDLE, LOAD, WRITE, RUN, HALT.
- **IDLE**
  - `cpu_rst_n_o` is 0 and `byte_ready_o` is 0.
  - On `start_i`: `err_o` is cleared. If `len_i` is 0 or greater than WORDS, set `err_o` and stay in IDLE. Otherwise latch `len_i`, clear the address and byte counters, and go to LOAD.
- **LOAD**
  - `byte_ready_o` is 1.
  - Each cycle with `byte_valid_i & byte_ready_o`: `word <= {word[23:0], byte_data_i}` and the byte counter increments (2 bits).
  - Acceptance of the 4th byte moves to WRITE.
  - Gaps in `byte_valid_i` stall the loader with no timeout.
- **WRITE**
  - One cycle: `im_we_o` = 1, with `im_addr_o` = address and `im_wdata_o` = word. `byte_ready_o` is 0.
  - If address == len−1, go to RUN with the run counter at 0. Otherwise increment the address and return to LOAD.
- **RUN**
  - `cpu_rst_n_o` is 1 and the run counter increments every cycle.
  - When the counter reaches RUN_CYCLES−1, go to HALT.
- **HALT**
  - `halt_o` is 1 and `cpu_rst_n_o` stays 1. The CPU is not stopped; `halt_o` only marks the sampling point.
- `start_i` in RUN or HALT behaves exactly as in IDLE, including the length check. A legal length immediately re-enters LOAD with `cpu_rst_n_o` = 0. An illegal length goes to IDLE with `err_o` set.
- `start_i` in LOAD or WRITE is ignored.
- Instruction memory words beyond `len` are not touched.

## Timing
- Reset values: state IDLE; `cpu_rst_n_o`, `byte_ready_o`, `im_we_o`, `busy_o`, `halt_o` and `err_o` all 0; `im_addr_o` and `im_wdata_o` 0.
- All outputs are registered or decoded from the state register; there is no combinational path from inputs to outputs.
- A byte is accepted on the rising edge where valid and ready are both high.
- `im_we_o` is high in the cycle after the edge that accepted the 4th byte.
- Minimum throughput is 5 cycles per word, so an N-word load takes at least 5N cycles from the first byte.
- `cpu_rst_n_o` rises on the first RUN cycle. The CPU therefore sees exactly RUN_CYCLES rising edges out of reset before `halt_o` rises.
- `rst_i` asserted mid-operation:
  - Returns to IDLE immediately (asynchronously).
  - `im_we_o` and `cpu_rst_n_o` drop without waiting for a clock edge.
  - Any partial word is discarded; instruction memory words already written keep their contents.

## Structure
- Shared package `prog_loader_pkg` holds:
  - the state enum `loader_state_t` {IDLE, LOAD, WRITE, RUN, HALT};
  - the constant `WORD_BYTES` = 4.
- One sub-module, `word_packer`:
  - byte shift register plus 2-bit byte counter;
  - ports: clear, accept, byte in, word out, `word_full`.
- The FSM, address counter and run counter live in the top module.

## Test plan
- **Three-word load.** `len_i` = 3, bytes 8C 01 00 04 / 20 02 00 05 / 00 22 18 20 sent back-to-back.
  - Writes occur at addr 0, 1, 2 with 0x8C010004, 0x20020005, 0x00221820.
  - `cpu_rst_n_o` rises 15 cycles after the first byte.
  - `halt_o` rises exactly RUN_CYCLES cycles later.
- **Stalled stream.** `byte_valid_i` is dropped for 7 cycles between bytes 2 and 3 of word 0.
  - No write occurs until the 4th byte; the written word is still correct.
- **Illegal lengths.** `len_i` = 0, then `len_i` = WORDS+1.
  - `err_o` = 1 and the loader stays in IDLE with no `im_we_o`.
  - A following `start_i` with `len_i` = 1 clears `err_o`.
- **Restart from HALT.** `start_i` with `len_i` = 2 while in HALT.
  - `cpu_rst_n_o` goes to 0 on the next edge and `halt_o` goes to 0.
  - Addresses 0 and 1 are rewritten.
- **Reset mid-word.** `rst_i` is pulsed after byte 2 of word 1 with `len_i` = 4.
  - All outputs return to their reset values asynchronously.
  - A subsequent load starts at address 0 with a fresh byte count.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared types and constants for the program loader
package prog_loader_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        RUN   = 3'd3,
        HALT  = 3'd4
    } loader_state_t;

    // Bytes per instruction word
    localparam int WORD_BYTES = 4;

    // A load length is usable only if it names at least one word and fits the memory
    function automatic logic len_is_legal(input int len, input int words);
        return (len >= 1) && (len <= words);
    endfunction

endpackage

// File: rtl/prog_loader_word_packer.sv
// rtl/prog_loader_word_packer.sv - big-endian byte-to-word shift register
module word_packer
    import prog_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);

    logic [31:0] word_q, word_d;
    logic [1:0]  cnt_q, cnt_d;

    // The first byte shifted in ends up in bits [31:24]; the 2-bit count wraps after a full word
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (accept_i) begin
            word_d = {word_q[23:0], byte_i};
            cnt_d  = cnt_q + 2'd1;
        end
    end

    // State registers; an asynchronous reset drops any partial word
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_o      = word_q;
    assign word_full_o = accept_i && (cnt_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - loads instruction memory from a byte stream and runs the CPU for a fixed budget
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter  int WORDS      = 128,
    parameter  int RUN_CYCLES = 600,
    localparam int AW         = $clog2(WORDS),
    localparam int RW         = $clog2(RUN_CYCLES)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [AW:0]   len_i,
    input  logic          byte_valid_i,
    input  logic [7:0]    byte_data_i,
    output logic          byte_ready_o,
    output logic          im_we_o,
    output logic [AW-1:0] im_addr_o,
    output logic [31:0]   im_wdata_o,
    output logic          cpu_rst_n_o,
    output logic          busy_o,
    output logic          halt_o,
    output logic          err_o
);

    loader_state_t state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   len_q, len_d;
    logic [RW-1:0] run_q, run_d;
    logic          err_q, err_d;

    logic          start_ok;
    logic          len_ok;
    logic          last_word;
    logic          pk_clear;
    logic          pk_accept;
    logic          pk_full;
    logic [31:0]   pk_word;

    // Start is honoured only while no load is in progress
    assign start_ok  = start_i && ((state_q == IDLE) || (state_q == RUN) || (state_q == HALT));
    assign len_ok    = len_is_legal(int'(len_i), WORDS);
    assign last_word = ({1'b0, addr_q} == (len_q - (AW+1)'(1)));
    assign pk_accept = byte_valid_i && (state_q == LOAD);

    word_packer u_packer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (pk_clear),
        .accept_i    (pk_accept),
        .byte_i      (byte_data_i),
        .word_o      (pk_word),
        .word_full_o (pk_full)
    );

    // Next-state logic: load/write loop, run budget, and start handling that overrides RUN/HALT
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        run_d    = run_q;
        err_d    = err_q;
        pk_clear = 1'b0;

        case (state_q)
            LOAD: begin
                if (pk_full) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (last_word) begin
                    state_d = RUN;
                    run_d   = '0;
                end else begin
                    addr_d  = addr_q + AW'(1);
                    state_d = LOAD;
                end
            end
            RUN: begin
                run_d = run_q + RW'(1);
                if (run_q == RW'(RUN_CYCLES - 1)) begin
                    state_d = HALT;
                end
            end
            default: ;
        endcase

        // A rejected length parks the loader in IDLE with the error flag up
        if (start_ok) begin
            err_d = !len_ok;
            if (len_ok) begin
                len_d    = len_i;
                addr_d   = '0;
                pk_clear = 1'b1;
                state_d  = LOAD;
            end else begin
                state_d  = IDLE;
            end
        end
    end

    // State registers with asynchronous reset back to IDLE
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            run_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            run_q   <= run_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode the state register so reset reaches them without a clock edge
    assign byte_ready_o = (state_q == LOAD);
    assign im_we_o      = (state_q == WRITE);
    assign im_addr_o    = addr_q;
    assign im_wdata_o   = pk_word;
    assign cpu_rst_n_o  = (state_q == RUN) || (state_q == HALT);
    assign busy_o       = (state_q == LOAD) || (state_q == WRITE);
    assign halt_o       = (state_q == HALT);
    assign err_o        = err_q;

endmodule
